// File: rtl/requant_sram_writer.sv
// rtl/requant_sram_writer.sv - packs requantized elements into SRAM words and writes them out
// Optional feature macro: SRAM_WRITER_ZERO_PAD_EN (final partial word written with a full lane mask)
module requant_sram_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int SRAM_WIDTH = 64,
  parameter int ADDR_WIDTH = 13,
  parameter int CNT_WIDTH  = 18,
  localparam int LANES     = SRAM_WIDTH / DATA_WIDTH,
  localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  total_count,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  data_ready_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [SRAM_WIDTH-1:0] sram_wdata_o,
  output logic [LANES-1:0]      sram_wmask_o,
  input  logic                  sram_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  elem_cnt_o,
  output logic                  error_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [LANE_W-1:0]     lane_cnt;
  logic [SRAM_WIDTH-1:0] pack_data;
  logic [LANES-1:0]      pack_mask;
  logic                  pack_full;
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [SRAM_WIDTH-1:0] wr_data;
  logic [LANES-1:0]      wr_mask;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  total_q;
  logic [CNT_WIDTH-1:0]  elem_cnt;
  logic                  error_q;

  logic                  start_ok, accept, last_elem, word_done, wr_free, wr_fire;
  logic [SRAM_WIDTH-1:0] word_data;
  logic [LANES-1:0]      word_mask;

  assign data_ready_o = (state == S_RUN) && !pack_full;
  assign start_ok     = start && (state == S_IDLE);
  assign accept       = data_valid_i && data_ready_o;
  assign last_elem    = accept && ((elem_cnt + CNT_WIDTH'(1)) == total_q);
  assign word_done    = accept && ((lane_cnt == LANE_W'(LANES - 1)) || last_elem);
  assign wr_fire      = wr_valid && sram_ready_i;
  // the write register can take a new word when empty or when its word leaves this edge
  assign wr_free      = !wr_valid || sram_ready_i;

  assign sram_we_o    = wr_valid;
  assign sram_addr_o  = wr_addr;
  assign sram_wdata_o = wr_data;
  assign sram_wmask_o = wr_mask;
  assign busy_o       = (state == S_RUN) || (state == S_DRAIN);
  assign done_o       = (state == S_DONE);
  assign elem_cnt_o   = elem_cnt;
  assign error_o      = error_q;

  // merge the incoming element into the pack word and build its lane mask
  always_comb begin
    word_data = pack_data;
    word_data[lane_cnt * DATA_WIDTH +: DATA_WIDTH] = data_i;
    word_mask = '0;
`ifdef SRAM_WRITER_ZERO_PAD_EN
    word_mask = '1;
`else
    for (int k = 0; k < LANES; k++) begin
      word_mask[k] = (LANE_W'(k) <= lane_cnt);
    end
`endif
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (total_count == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last_elem) state_nxt = S_DRAIN;
      S_DRAIN: if (!wr_valid && !pack_full) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // pack register, write register, address and element counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_cnt  <= '0;
      pack_data <= '0;
      pack_mask <= '0;
      pack_full <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_mask   <= '0;
      addr_q    <= '0;
      total_q   <= '0;
      elem_cnt  <= '0;
    end else begin
      if (start_ok) begin
        addr_q    <= base_addr;
        total_q   <= total_count;
        elem_cnt  <= '0;
        lane_cnt  <= '0;
        pack_data <= '0;
        pack_full <= 1'b0;
      end
      if (accept) begin
        elem_cnt <= (elem_cnt == total_q) ? elem_cnt : elem_cnt + CNT_WIDTH'(1);
        lane_cnt <= word_done ? '0 : lane_cnt + LANE_W'(1);
        // a finished word either leaves now (pack cleared) or parks here until the writer frees up
        pack_data <= (word_done && wr_free) ? '0 : word_data;
        if (word_done && !wr_free) begin
          pack_full <= 1'b1;
          pack_mask <= word_mask;
        end
      end
      if (word_done && wr_free) begin
        wr_valid <= 1'b1;
        wr_addr  <= addr_q;
        wr_data  <= word_data;
        wr_mask  <= word_mask;
        addr_q   <= addr_q + ADDR_WIDTH'(1);
      end else if (pack_full && wr_free) begin
        wr_valid  <= 1'b1;
        wr_addr   <= addr_q;
        wr_data   <= pack_data;
        wr_mask   <= pack_mask;
        addr_q    <= addr_q + ADDR_WIDTH'(1);
        pack_full <= 1'b0;
        pack_data <= '0;
      end else if (wr_fire) begin
        wr_valid <= 1'b0;
      end
    end
  end

  // sticky protocol error: stray data outside RUN or start while busy
  always_ff @(posedge clk) begin
    if (!rst) begin
      error_q <= 1'b0;
    end else if ((start && busy_o) || (data_valid_i && (state != S_RUN))) begin
      error_q <= 1'b1;
    end else if (start_ok) begin
      error_q <= 1'b0;
    end
  end

endmodule

// File: doc/requant_sram_writer.md
REQUANT_SRAM_WRITER -- requirements
Module: requant_sram_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one requantized signed element.
REQ-002 Parameter SRAM_WIDTH, default 64: SRAM word width; LANES = SRAM_WIDTH/DATA_WIDTH, default 8.
REQ-003 Parameter ADDR_WIDTH, default 13: SRAM word address width.
REQ-004 Parameter CNT_WIDTH, default 18: element counter width.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle pulse; latches base_addr and total_count.
REQ-008 base_addr  in  ADDR_WIDTH  first SRAM word address of the output tensor.
REQ-009 total_count  in  CNT_WIDTH  number of elements expected for this job.
REQ-010 data_valid_i  in  1  requantized element present on data_i.
REQ-011 data_i  in  DATA_WIDTH  signed requantized element.
REQ-012 data_ready_o  out  1  element accepted on an edge where data_valid_i && data_ready_o.
REQ-013 sram_we_o  out  1  write request; held until sram_ready_i.
REQ-014 sram_addr_o  out  ADDR_WIDTH  write address.
REQ-015 sram_wdata_o  out  SRAM_WIDTH  packed word; element k of a word occupies bits [DATA_WIDTH*k +: DATA_WIDTH].
REQ-016 sram_wmask_o  out  LANES  byte-lane write enable.
REQ-017 sram_ready_i  in  1  write accepted on an edge where sram_we_o && sram_ready_i.
REQ-018 busy_o  out  1  job in progress.
REQ-019 done_o  out  1  one-cycle pulse after the final word is accepted.
REQ-020 elem_cnt_o  out  CNT_WIDTH  elements accepted in current job.
REQ-021 error_o  out  1  sticky protocol error.

Function
REQ-022 States IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with total_count>0; IDLE->DONE on start with total_count==0; RUN->DRAIN when the last element is accepted; DRAIN->DONE when the write register is empty and the pack register empty; DONE->IDLE after one cycle.
REQ-023 Two storage stages: pack register (lane counter 0..LANES-1) and write register (drives sram_* outputs).
REQ-024 Accepted element written into pack lane lane_cnt; lane_cnt increments, wraps to 0 when a word completes.
REQ-025 A word completes on the accept of lane LANES-1 or of the job's last element (partial word).
REQ-026 Completed word moves into the write register on the same edge if the write register is empty or is being accepted that cycle; otherwise it stays in the pack register (pack_full).
REQ-027 data_ready_o = (state==RUN) && !pack_full; combinational, no dependence on data_valid_i.
REQ-028 sram_we_o rises the cycle after the completing element is accepted when no stall; latency 1 cycle.
REQ-029 Word address = base_addr + word index, modulo 2^ADDR_WIDTH (wraps at all-ones to 0).
REQ-030 sram_addr_o, sram_wdata_o, sram_wmask_o stable while sram_we_o high and sram_ready_i low.
REQ-031 Full words: sram_wmask_o all ones.
REQ-032 Sustained throughput: one element per cycle while sram_ready_i stays high.
REQ-033 done_o asserted for exactly one cycle in DONE; busy_o high in RUN and DRAIN only.
REQ-034 data_valid_i high in IDLE, DRAIN or DONE: element dropped, error_o set.
REQ-035 start while busy_o: ignored, error_o set, job continues unchanged.
REQ-036 error_o cleared by an accepted start in IDLE.
REQ-037 elem_cnt_o cleared on accepted start; saturates at total_count.

Reset
REQ-038 rst low at any edge, including mid-job: state IDLE, both registers empty, lane_cnt 0, discard partial data.
REQ-039 Reset values: data_ready_o 0, sram_we_o 0, sram_addr_o 0, sram_wdata_o 0, sram_wmask_o 0, busy_o 0, done_o 0, elem_cnt_o 0, error_o 0.

Configuration
REQ-040 Macro SRAM_WRITER_ZERO_PAD_EN defined: final partial word has unused lanes zeroed and sram_wmask_o all ones.
REQ-041 Macro SRAM_WRITER_ZERO_PAD_EN undefined: unused lanes zeroed, sram_wmask_o bit k set only for filled lanes (e.g. 3 filled -> 8'b00000111).

Verification
REQ-042 base_addr=10, total_count=16, data 0..15 back-to-back, sram_ready_i=1 -> writes addr 10 data 0x0706050403020100, addr 11 data 0x0F0E0D0C0B0A0908, done_o pulse, no stall.
REQ-043 total_count=11, ZERO_PAD undefined -> second write addr base+1, lanes 0-2 = elements 8-10, mask 8'b00000111; defined -> mask 8'hFF.
REQ-044 total_count=24, sram_ready_i low 20 cycles -> data_ready_o drops after word 2 completes, no element lost, 3 writes in order, word data held stable.
REQ-045 base_addr=8191, total_count=16 -> writes to 8191 then 0.
REQ-046 data_valid_i in IDLE, then start while busy -> error_o=1 sticky, job output unchanged; next start clears error_o.
REQ-047 rst low after 5 of 16 elements -> all outputs reset values next cycle; new job writes from lane 0 with no stale data.
